// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode and control state definitions for the 8-bit RISC CPU
package cpu_defs;

    // Opcodes carried in instruction register bits [15:13]
    localparam logic [2:0] HLT  = 3'b000;
    localparam logic [2:0] SKZ  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] ANDD = 3'b011;
    localparam logic [2:0] XORR = 3'b100;
    localparam logic [2:0] LDA  = 3'b101;
    localparam logic [2:0] STO  = 3'b110;
    localparam logic [2:0] JMP  = 3'b111;

    // Control FSM states: IDLE plus the eight clocks of an instruction cycle
    typedef enum logic [3:0] {
        ST_IDLE = 4'd8,
        ST_S0   = 4'd0,
        ST_S1   = 4'd1,
        ST_S2   = 4'd2,
        ST_S3   = 4'd3,
        ST_S4   = 4'd4,
        ST_S5   = 4'd5,
        ST_S6   = 4'd6,
        ST_S7   = 4'd7
    } state_t;

    // Opcodes that read an operand and route it through the ALU to the accumulator
    function automatic logic is_data_op(input logic [2:0] op);
        return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - eight-clock instruction cycle control FSM with registered strobes
module cpu_ctrl
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       rd,
    output logic       wr,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt
);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       zero_q, zero_d;

    logic load_ir_q, load_ir_d;
    logic rd_q, rd_d;
    logic wr_q, wr_d;
    logic inc_pc_q, inc_pc_d;
    logic load_pc_q, load_pc_d;
    logic alu_ena_q, alu_ena_d;
    logic load_acc_q, load_acc_d;
    logic datactl_ena_q, datactl_ena_d;
    logic halt_q, halt_d;

    // Next state and opcode/zero capture at the end of S2
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: state_d = ena ? ST_S0 : ST_IDLE;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2: begin
                state_d = ST_S3;
                op_d    = opcode;
                zero_d  = zero;
            end
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = ST_S5;
            ST_S5:   state_d = ST_S6;
            ST_S6:   state_d = ST_S7;
            ST_S7:   state_d = ena ? ST_S0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decoded from the state being entered, so each flop is high during that state
    always_comb begin
        load_ir_d     = 1'b0;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        inc_pc_d      = 1'b0;
        load_pc_d     = 1'b0;
        alu_ena_d     = 1'b0;
        load_acc_d    = 1'b0;
        datactl_ena_d = 1'b0;
        halt_d        = 1'b0;
        case (state_d)
            ST_S0, ST_S1: begin
                rd_d      = 1'b1;
                load_ir_d = 1'b1;
                inc_pc_d  = 1'b1;
            end
            ST_S3: halt_d = (op_d == HLT);
            ST_S4: begin
                rd_d          = is_data_op(op_d);
                datactl_ena_d = (op_d == STO);
                load_pc_d     = (op_d == JMP);
                halt_d        = (op_d == HLT);
            end
            ST_S5: begin
                rd_d          = is_data_op(op_d);
                alu_ena_d     = is_data_op(op_d);
                datactl_ena_d = (op_d == STO);
                wr_d          = (op_d == STO);
                halt_d        = (op_d == HLT);
            end
            ST_S6: begin
                load_acc_d    = is_data_op(op_d);
                datactl_ena_d = (op_d == STO);
                inc_pc_d      = (op_d == SKZ) && zero_d;
                halt_d        = (op_d == HLT);
            end
            ST_S7: begin
                inc_pc_d = (op_d == SKZ) && zero_d;
                halt_d   = (op_d == HLT);
            end
            default: ;
        endcase
    end

    // State, latched decode inputs and output strobes; reset clears all at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= 3'b000;
            zero_q        <= 1'b0;
            load_ir_q     <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            inc_pc_q      <= 1'b0;
            load_pc_q     <= 1'b0;
            alu_ena_q     <= 1'b0;
            load_acc_q    <= 1'b0;
            datactl_ena_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            zero_q        <= zero_d;
            load_ir_q     <= load_ir_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            inc_pc_q      <= inc_pc_d;
            load_pc_q     <= load_pc_d;
            alu_ena_q     <= alu_ena_d;
            load_acc_q    <= load_acc_d;
            datactl_ena_q <= datactl_ena_d;
            halt_q        <= halt_d;
        end
    end

    assign load_ir     = load_ir_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign inc_pc      = inc_pc_q;
    assign load_pc     = load_pc_q;
    assign alu_ena     = alu_ena_q;
    assign load_acc    = load_acc_q;
    assign datactl_ena = datactl_ena_q;
    assign halt        = halt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl against an instruction-level model
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic load_ir, rd, wr, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt;

    int checks   = 0;
    int failures = 0;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc), .load_pc(load_pc),
        .alu_ena(alu_ena), .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Observed strobes packed as {load_ir,rd,wr,inc_pc,load_pc,alu_ena,load_acc,datactl_ena,halt}
    function automatic logic [8:0] obs();
        return {load_ir, rd, wr, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt};
    endfunction

    // Reference: which strobes an instruction asserts on clock k of its cycle
    function automatic logic [8:0] model(input int k, input logic [2:0] op, input logic z);
        bit data  = (op >= 3'd2) && (op <= 3'd5);
        bit fetch = (k < 2);
        bit late  = (k >= 3);
        bit m_ir  = fetch;
        bit m_rd  = fetch || (data && (k == 4 || k == 5));
        bit m_wr  = (op == 3'd6) && (k == 5);
        bit m_inc = fetch || ((op == 3'd1) && z && k >= 6);
        bit m_lpc = (op == 3'd7) && (k == 4);
        bit m_alu = data && (k == 5);
        bit m_acc = data && (k == 6);
        bit m_dct = (op == 3'd6) && (k >= 4) && (k <= 6);
        bit m_hlt = (op == 3'd0) && late;
        return {m_ir, m_rd, m_wr, m_inc, m_lpc, m_alu, m_acc, m_dct, m_hlt};
    endfunction

    task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Runs one instruction from S0; rst_at in 0..7 pulses reset in that clock, cont=0 goes idle after
    task automatic run_instr(input logic [2:0] op, input logic z, input bit cont, input int rst_at);
        int incs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("op%0d_z%0d_s%0d", op, z, k), obs(), model(k, op, z));
            checks++;
            assert (!(rd && wr) && !(wr && !datactl_ena) && !(load_pc && inc_pc)) else begin
                failures++;
                $error("FAIL invariant_s%0d observed=%b expected=no_conflict", k, obs());
            end
            incs += int'(inc_pc);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("reset_in_s%0d", k), obs(), 9'b0);
                #2;
                rst_n = 1'b1;
                ena   = 1'b1;
                return;
            end
            opcode = (k == 2) ? op : 3'($urandom);
            zero   = (k == 2) ? z  : 1'($urandom);
            ena    = (k == 7) ? cont : ((k >= 3 && !cont) ? 1'b0 : 1'($urandom));
        end
        checks++;
        assert (incs == ((op == 3'd1 && z) ? 4 : 2)) else begin
            failures++;
            $error("FAIL inc_pc_count observed=%0d expected=%0d", incs, (op == 3'd1 && z) ? 4 : 2);
        end
        if (!cont) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                check("idle_after_drop", obs(), 9'b0);
            end
            ena = 1'b1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        #12;
        check("reset_state", obs(), 9'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ena_low", obs(), 9'b0);
        ena = 1'b1;

        run_instr(3'd5, 1'b0, 1'b1, 8);   // LDA
        run_instr(3'd6, 1'b0, 1'b1, 8);   // STO
        run_instr(3'd1, 1'b1, 1'b1, 8);   // SKZ taken
        run_instr(3'd1, 1'b0, 1'b1, 8);   // SKZ not taken
        run_instr(3'd7, 1'b0, 1'b1, 8);   // JMP
        run_instr(3'd0, 1'b0, 1'b1, 8);   // HLT
        run_instr(3'd2, 1'b1, 1'b1, 8);   // ADD
        run_instr(3'd3, 1'b0, 1'b1, 8);   // AND
        run_instr(3'd4, 1'b1, 1'b1, 8);   // XOR
        run_instr(3'd6, 1'b1, 1'b0, 8);   // STO then ena dropped from S3
        run_instr(3'd6, 1'b0, 1'b1, 5);   // STO with reset pulse in S5
        run_instr(3'd5, 1'b0, 1'b1, 8);   // fetch resumes after reset

        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
